alu_result_writeback: RTL and testbench

- Downstream stage of the datapath ALU. Captures the ALU's 64-bit combinational result into the Z register pair (ZHI/ZLO) on a capture strobe.
- Derives zero and negative condition flags from the captured value.
- Sequences the write-back to the register file over a valid/ready port:
  - one beat to a general register for single-word ops;
  - two beats (LO, then HI) for multiply and divide.
- Sits between the ALU output and the register-file write port.

---
 rtl/alu_result_writeback.sv | 143 ++++++++++++++
 tb/tb_alu_result_writeback.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_writeback.sv
// ALU result capture into ZHI/ZLO with condition flags, plus a valid/ready
// write-back sequencer (one beat for single-word ops, LO then HI for mul/div).
module alu_result_writeback #(
    parameter int unsigned     DATA_W = 32,
    parameter int unsigned     OP_W   = 5,
    parameter logic [OP_W-1:0] MUL_OP = OP_W'(5'b01111),
    parameter logic [OP_W-1:0] DIV_OP = OP_W'(5'b10000)
) (
    input  logic                clk,
    input  logic                clear_n,
    input  logic                zin,
    input  logic [2*DATA_W-1:0] alu_result,
    input  logic [OP_W-1:0]     alu_op,
    input  logic [3:0]          dest_reg,
    output logic [DATA_W-1:0]   zlo_out,
    output logic [DATA_W-1:0]   zhi_out,
    output logic                flag_z,
    output logic                flag_n,
    output logic                busy,
    output logic                overrun,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [DATA_W-1:0]   wb_data,
    output logic [1:0]          wb_sel,
    output logic [3:0]          wb_reg
);

    typedef enum logic [1:0] {StIdle, StWbGpr, StWbLo, StWbHi} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   zlo_q, zlo_d, zhi_q, zhi_d;
    logic                fz_q, fz_d, fn_q, fn_d, ovr_q, ovr_d;
    logic [3:0]          dest_q, dest_d;
    logic                valid_q, valid_d;
    logic [1:0]          sel_q, sel_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [3:0]          reg_q, reg_d;
    logic                two_word;

    assign two_word = (alu_op == MUL_OP) || (alu_op == DIV_OP);

    always_comb begin
        state_d = state_q;
        zlo_d   = zlo_q;
        zhi_d   = zhi_q;
        fz_d    = fz_q;
        fn_d    = fn_q;
        ovr_d   = ovr_q;
        dest_d  = dest_q;
        unique case (state_q)
            StIdle: begin
                if (zin) begin
                    zlo_d  = alu_result[DATA_W-1:0];
                    dest_d = dest_reg;
                    ovr_d  = 1'b0;
                    if (two_word) begin
                        zhi_d   = alu_result[2*DATA_W-1:DATA_W];
                        fz_d    = (alu_result == '0);
                        fn_d    = alu_result[2*DATA_W-1];
                        state_d = StWbLo;
                    end else begin
                        zhi_d   = '0;
                        fz_d    = (alu_result[DATA_W-1:0] == '0);
                        fn_d    = alu_result[DATA_W-1];
                        state_d = StWbGpr;
                    end
                end
            end
            StWbGpr: if (wb_ready) state_d = StIdle;
            StWbLo:  if (wb_ready) state_d = StWbHi;
            StWbHi:  if (wb_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // A strobe while busy is dropped, even in the final-beat cycle.
        if (state_q != StIdle && zin) ovr_d = 1'b1;
    end

    // Beat outputs are registered off the next state so they hold under backpressure.
    always_comb begin
        valid_d = 1'b0;
        sel_d   = 2'b00;
        data_d  = '0;
        reg_d   = '0;
        unique case (state_d)
            StWbGpr: begin
                valid_d = 1'b1;
                reg_d   = dest_d;
                data_d  = zlo_d;
            end
            StWbLo: begin
                valid_d = 1'b1;
                sel_d   = 2'b01;
                data_d  = zlo_d;
            end
            StWbHi: begin
                valid_d = 1'b1;
                sel_d   = 2'b10;
                data_d  = zhi_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= StIdle;
            zlo_q   <= '0;
            zhi_q   <= '0;
            fz_q    <= 1'b0;
            fn_q    <= 1'b0;
            ovr_q   <= 1'b0;
            dest_q  <= '0;
            valid_q <= 1'b0;
            sel_q   <= 2'b00;
            data_q  <= '0;
            reg_q   <= '0;
        end else begin
            state_q <= state_d;
            zlo_q   <= zlo_d;
            zhi_q   <= zhi_d;
            fz_q    <= fz_d;
            fn_q    <= fn_d;
            ovr_q   <= ovr_d;
            dest_q  <= dest_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            reg_q   <= reg_d;
        end
    end

    assign zlo_out  = zlo_q;
    assign zhi_out  = zhi_q;
    assign flag_z   = fz_q;
    assign flag_n   = fn_q;
    assign overrun  = ovr_q;
    assign busy     = (state_q != StIdle);
    assign wb_valid = valid_q;
    assign wb_sel   = sel_q;
    assign wb_data  = data_q;
    assign wb_reg   = reg_q;

endmodule

// File: tb/tb_alu_result_writeback.sv
// Bench for alu_result_writeback: directed vector table, random traffic against
// a beat-queue reference model, and an asynchronous reset mid write-back.
module tb_alu_result_writeback;

    localparam logic [4:0] MUL = 5'b01111;
    localparam logic [4:0] DIV = 5'b10000;

    logic        clk = 1'b0;
    logic        clear_n;
    logic        zin;
    logic [63:0] alu_result;
    logic [4:0]  alu_op;
    logic [3:0]  dest_reg;
    logic [31:0] zlo_out, zhi_out, wb_data;
    logic        flag_z, flag_n, busy, overrun, wb_valid, wb_ready;
    logic [1:0]  wb_sel;
    logic [3:0]  wb_reg;

    int checks = 0;
    int failures = 0;

    alu_result_writeback dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .zin        (zin),
        .alu_result (alu_result),
        .alu_op     (alu_op),
        .dest_reg   (dest_reg),
        .zlo_out    (zlo_out),
        .zhi_out    (zhi_out),
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .busy       (busy),
        .overrun    (overrun),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_data    (wb_data),
        .wb_sel     (wb_sel),
        .wb_reg     (wb_reg)
    );

    always #5 clk = ~clk;

    // Reference model: pending write-back beats as a queue.
    typedef struct packed {
        logic [1:0]  sel;
        logic [3:0]  rg;
        logic [31:0] data;
    } beat_t;

    beat_t       q[$];
    logic [31:0] m_zlo, m_zhi;
    logic        m_fz, m_fn, m_ovr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_zlo = 0; m_zhi = 0; m_fz = 0; m_fn = 0; m_ovr = 0;
    endtask

    task automatic model_edge();
        bit two;
        if (q.size() == 0) begin
            if (zin) begin
                two   = (alu_op == MUL) || (alu_op == DIV);
                m_zlo = alu_result[31:0];
                m_ovr = 0;
                if (two) begin
                    m_zhi = alu_result[63:32];
                    m_fz  = (alu_result == 64'd0);
                    m_fn  = alu_result[63];
                    q.push_back('{sel: 2'b01, rg: 4'd0, data: alu_result[31:0]});
                    q.push_back('{sel: 2'b10, rg: 4'd0, data: alu_result[63:32]});
                end else begin
                    m_zhi = 0;
                    m_fz  = (alu_result[31:0] == 32'd0);
                    m_fn  = alu_result[31];
                    q.push_back('{sel: 2'b00, rg: dest_reg, data: alu_result[31:0]});
                end
            end
        end else begin
            if (zin) m_ovr = 1;
            if (wb_ready) void'(q.pop_front());
        end
    endtask

    task automatic model_compare();
        beat_t h;
        h = (q.size() != 0) ? q[0] : '0;
        chk("m_valid", 64'(wb_valid), 64'(q.size() != 0));
        chk("m_busy", 64'(busy), 64'(q.size() != 0));
        chk("m_sel", 64'(wb_sel), 64'(h.sel));
        chk("m_reg", 64'(wb_reg), 64'(h.rg));
        chk("m_data", 64'(wb_data), 64'(h.data));
        chk("m_zlo", 64'(zlo_out), 64'(m_zlo));
        chk("m_zhi", 64'(zhi_out), 64'(m_zhi));
        chk("m_flags", {62'd0, flag_z, flag_n}, {62'd0, m_fz, m_fn});
        chk("m_overrun", 64'(overrun), 64'(m_ovr));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        model_compare();
    endtask

    typedef struct {
        logic        zin;
        logic [63:0] res;
        logic [4:0]  op;
        logic [3:0]  dst;
        logic        rdy;
        logic        valid;
        logic [1:0]  sel;
        logic [31:0] data;
        logic [3:0]  rg;
        logic        bsy, fz, fn, ovr;
        logic [31:0] zlo, zhi;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic z, input logic [63:0] res, input logic [4:0] op,
                       input logic [3:0] dst, input logic rdy, input logic valid,
                       input logic [1:0] sel, input logic [31:0] data, input logic [3:0] rg,
                       input logic bsy, input logic fz, input logic fn, input logic ovr,
                       input logic [31:0] zlo, input logic [31:0] zhi);
        vec_t v;
        v = '{z, res, op, dst, rdy, valid, sel, data, rg, bsy, fz, fn, ovr, zlo, zhi};
        vecs.push_back(v);
    endtask

    initial begin
        // ADD then idle
        add(1, 64'h7, 5'h03, 4'd5, 1, 1, 2'b00, 32'h7, 4'd5, 1, 0, 0, 0, 32'h7, 32'h0);
        add(0, 64'h0, 5'h00, 4'd0, 1, 0, 2'b00, 32'h0, 4'd0, 0, 0, 0, 0, 32'h7, 32'h0);
        // MUL, two consecutive beats
        add(1, 64'hFFFFFFFF_FFFFFFFA, MUL, 4'd0, 1, 1, 2'b01, 32'hFFFFFFFA, 4'd0, 1, 0, 1, 0,
            32'hFFFFFFFA, 32'hFFFFFFFF);
        add(0, 64'h0, 5'h00, 4'd0, 1, 1, 2'b10, 32'hFFFFFFFF, 4'd0, 1, 0, 1, 0,
            32'hFFFFFFFA, 32'hFFFFFFFF);
        add(0, 64'h0, 5'h00, 4'd0, 1, 0, 2'b00, 32'h0, 4'd0, 0, 0, 1, 0,
            32'hFFFFFFFA, 32'hFFFFFFFF);
        // DIV with 4 cycles of backpressure on the LO beat
        add(1, 64'h00000003_00000002, DIV, 4'd0, 0, 1, 2'b01, 32'h2, 4'd0, 1, 0, 0, 0, 32'h2, 32'h3);
        for (int i = 0; i < 4; i++)
            add(0, 64'h0, 5'h00, 4'd0, 0, 1, 2'b01, 32'h2, 4'd0, 1, 0, 0, 0, 32'h2, 32'h3);
        add(0, 64'h0, 5'h00, 4'd0, 1, 1, 2'b10, 32'h3, 4'd0, 1, 0, 0, 0, 32'h2, 32'h3);
        add(0, 64'h0, 5'h00, 4'd0, 1, 0, 2'b00, 32'h0, 4'd0, 0, 0, 0, 0, 32'h2, 32'h3);
        // Overrun during LO and in the final-beat cycle; next capture clears it
        add(1, 64'h00000005_00000006, MUL, 4'd0, 0, 1, 2'b01, 32'h6, 4'd0, 1, 0, 0, 0, 32'h6, 32'h5);
        add(1, 64'h1234, 5'h03, 4'd7, 1, 1, 2'b10, 32'h5, 4'd0, 1, 0, 0, 1, 32'h6, 32'h5);
        add(1, 64'h0, 5'h03, 4'd7, 1, 0, 2'b00, 32'h0, 4'd0, 0, 0, 0, 1, 32'h6, 32'h5);
        add(1, 64'h0, 5'h04, 4'd9, 0, 1, 2'b00, 32'h0, 4'd9, 1, 1, 0, 0, 32'h0, 32'h0);
        add(0, 64'h0, 5'h00, 4'd0, 1, 0, 2'b00, 32'h0, 4'd0, 0, 1, 0, 0, 32'h0, 32'h0);
        // MUL whose low word is zero is not a zero result
        add(1, 64'h00000001_00000000, MUL, 4'd0, 1, 1, 2'b01, 32'h0, 4'd0, 1, 0, 0, 0, 32'h0, 32'h1);
        add(0, 64'h0, 5'h00, 4'd0, 1, 1, 2'b10, 32'h1, 4'd0, 1, 0, 0, 0, 32'h0, 32'h1);
        add(0, 64'h0, 5'h00, 4'd0, 1, 0, 2'b00, 32'h0, 4'd0, 0, 0, 0, 0, 32'h0, 32'h1);
        // Single-word flags ignore the upper half
        add(1, 64'hDEADBEEF_80000000, 5'h03, 4'd15, 1, 1, 2'b00, 32'h80000000, 4'd15, 1, 0, 1, 0,
            32'h80000000, 32'h0);
        add(0, 64'h0, 5'h00, 4'd0, 1, 0, 2'b00, 32'h0, 4'd0, 0, 0, 1, 0, 32'h80000000, 32'h0);
        add(1, 64'hFFFF0000_00000000, 5'h01, 4'd2, 1, 1, 2'b00, 32'h0, 4'd2, 1, 1, 0, 0, 32'h0, 32'h0);
        add(0, 64'h0, 5'h00, 4'd0, 1, 0, 2'b00, 32'h0, 4'd0, 0, 1, 0, 0, 32'h0, 32'h0);

        clear_n = 0; zin = 0; alu_result = 0; alu_op = 0; dest_reg = 0; wb_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        model_compare();
        @(negedge clk);
        clear_n = 1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            zin = vecs[i].zin; alu_result = vecs[i].res; alu_op = vecs[i].op;
            dest_reg = vecs[i].dst; wb_ready = vecs[i].rdy;
            step();
            chk($sformatf("v%0d_valid", i), 64'(wb_valid), 64'(vecs[i].valid));
            chk($sformatf("v%0d_sel", i), 64'(wb_sel), 64'(vecs[i].sel));
            chk($sformatf("v%0d_data", i), 64'(wb_data), 64'(vecs[i].data));
            chk($sformatf("v%0d_reg", i), 64'(wb_reg), 64'(vecs[i].rg));
            chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].bsy));
            chk($sformatf("v%0d_flags", i), {62'd0, flag_z, flag_n},
                {62'd0, vecs[i].fz, vecs[i].fn});
            chk($sformatf("v%0d_overrun", i), 64'(overrun), 64'(vecs[i].ovr));
            chk($sformatf("v%0d_zlo", i), 64'(zlo_out), 64'(vecs[i].zlo));
            chk($sformatf("v%0d_zhi", i), 64'(zhi_out), 64'(vecs[i].zhi));
        end

        // Random traffic with overruns and backpressure
        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            zin = ($urandom_range(0, 1) == 1);
            r = $urandom_range(0, 3);
            alu_op = (r == 0) ? MUL : (r == 1) ? DIV : 5'($urandom);
            r = $urandom_range(0, 7);
            alu_result = (r == 0) ? 64'd0 :
                         (r == 1) ? {$urandom, 32'd0} :
                         (r == 2) ? {32'd0, $urandom} : {$urandom, $urandom};
            dest_reg = 4'($urandom);
            wb_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        // Asynchronous reset while holding the HI beat
        zin = 0; wb_ready = 1;
        repeat (3) step();
        zin = 1; alu_result = 64'h80000009_00000004; alu_op = MUL; wb_ready = 1;
        step();
        zin = 0;
        step();
        wb_ready = 0;
        step();
        chk("pre_rst_sel", 64'(wb_sel), 64'(2'b10));
        #3;
        clear_n = 0;
        #1;
        model_reset();
        chk("rst_valid", 64'(wb_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_zlo", 64'(zlo_out), 64'd0);
        chk("rst_zhi", 64'(zhi_out), 64'd0);
        chk("rst_flags", {62'd0, flag_z, flag_n}, 64'd0);
        chk("rst_data", 64'(wb_data), 64'd0);
        #2;
        clear_n = 1;
        wb_ready = 1;
        repeat (3) begin
            step();
            chk("post_rst_valid", 64'(wb_valid), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
